// File: rtl/ibex_axi4l_master_if.sv
// rtl/ibex_axi4l_master_if.sv - AXI4-Lite types package and axi4l_if bus interface
package axi4l_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;
endpackage

interface axi4l_if
    import axi4l_pkg::*;
(
    input logic aclk,
    input logic aresetn
);
    logic  awvalid;
    logic  awready;
    addr_t awaddr;
    logic  wvalid;
    logic  wready;
    data_t wdata;
    strb_t wstrb;
    logic  bvalid;
    logic  bready;
    resp_t bresp;
    logic  arvalid;
    logic  arready;
    addr_t araddr;
    logic  rvalid;
    logic  rready;
    data_t rdata;
    resp_t rresp;

    modport master (
        input  aclk, aresetn,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  aclk, aresetn,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ibex_axi4l_master.sv
// rtl/ibex_axi4l_master.sv - Ibex req/gnt/rvalid port to AXI4-Lite initiator, one outstanding
// Optional posted writes with sticky wr_err_o: AXI4L_MASTER_POSTED_WR_EN
module ibex_axi4l_master
    import axi4l_pkg::*;
#(
    parameter bit READ_ONLY = 1'b0
) (
    axi4l_if.master axi,
    input  logic  req_i,
    output logic  gnt_o,
    input  logic  we_i,
    input  strb_t be_i,
    input  addr_t addr_i,
    input  data_t wdata_i,
    output logic  rvalid_o,
    output data_t rdata_o,
`ifdef AXI4L_MASTER_POSTED_WR_EN
    output logic  wr_err_o,
`endif
    output logic  err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        ERR
    } state_e;

    state_e state_q;
    addr_t  addr_q;
    data_t  wdata_q;
    strb_t  be_q;
    logic   awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic   rvalid_q, err_q;
    data_t  rdata_q;
`ifdef AXI4L_MASTER_POSTED_WR_EN
    logic   wr_err_q;
`endif

    // A channel is done once its valid has dropped or its handshake happens this cycle.
    logic aw_done_d, w_done_d;
    assign aw_done_d = !awvalid_q || axi.awready;
    assign w_done_d  = !wvalid_q  || axi.wready;

    // Transfers are word-aligned; the low address bits carry no information here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign gnt_o       = (state_q == IDLE) && req_i;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
`ifdef AXI4L_MASTER_POSTED_WR_EN
    assign wr_err_o    = wr_err_q;
`endif

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.rready  = rready_q;

    always_ff @(posedge axi.aclk) begin
        if (!axi.aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
`ifdef AXI4L_MASTER_POSTED_WR_EN
            wr_err_q  <= 1'b0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        addr_q  <= {addr_i[31:2], 2'b00};
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        if (!we_i) begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD;
                        end else if (READ_ONLY) begin
                            state_q   <= ERR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR;
                        end
                    end
                end
                WR: begin
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WAIT_B;
`ifdef AXI4L_MASTER_POSTED_WR_EN
                        rvalid_q <= 1'b1;
`endif
                    end
                end
                WAIT_B: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
`ifdef AXI4L_MASTER_POSTED_WR_EN
                        if (axi.bresp != OKAY) wr_err_q <= 1'b1;
`else
                        rvalid_q <= 1'b1;
                        err_q    <= (axi.bresp != OKAY);
`endif
                    end
                end
                RD: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= axi.rdata;
                        rvalid_q <= 1'b1;
                        err_q    <= (axi.rresp != OKAY);
                        state_q  <= IDLE;
                    end
                end
                ERR: begin
                    rvalid_q <= 1'b1;
                    err_q    <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
